// File: rtl/apb_seq_pkg.sv
// Shared types for the APB command sequencer: FSM states, master add_i encodings and the queued command.
package apb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } seq_state_t;

  localparam logic [1:0] ADD_NOP   = 2'b00;
  localparam logic [1:0] ADD_READ  = 2'b01;
  localparam logic [1:0] ADD_WRITE = 2'b11;

  typedef struct packed {
    logic        write;
    logic [31:0] wdata;
  } seq_cmd_t;

endpackage

// File: rtl/apb_seq_fifo.sv
// Synchronous DEPTH-entry command FIFO with occupancy count; DEPTH must be a power of two so pointers wrap naturally.
module apb_seq_fifo
  import apb_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          push,
  input  seq_cmd_t      push_data,
  input  logic          pop,
  output seq_cmd_t      pop_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  seq_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; only pointers and level define validity.
  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Feeds an APB add-master one command at a time from a FIFO and returns one response per command, in order.
// Optional WAIT timeout enabled by defining APB_SEQ_TIMEOUT_EN.
module apb_cmd_sequencer
  import apb_seq_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_write_i,
  input  logic [31:0]              cmd_wdata_i,
  output logic [1:0]               add_o,
  output logic [31:0]              wdata_o,
  input  logic                     ready_i,
  input  logic [31:0]              rdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic                     rsp_write_o,
  output logic [31:0]              rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("apb_cmd_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  seq_state_t state;
  seq_cmd_t   head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       cur_write;

  assign cmd_ready_o = !fifo_full;
  assign fifo_pop    = (state == IDLE) && !fifo_empty;

  apb_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .pclk      (pclk),
    .preset    (preset),
    .push      (cmd_valid_i && cmd_ready_o),
    .push_data ('{write: cmd_write_i, wdata: cmd_wdata_i}),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level_o)
  );

`ifdef APB_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt;
  logic          rsp_err_q;
  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      cur_write   <= 1'b0;
      add_o       <= ADD_NOP;
      wdata_o     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_write_o <= 1'b0;
      rsp_rdata_o <= '0;
`ifdef APB_SEQ_TIMEOUT_EN
      tmo_cnt     <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur_write <= head.write;
            wdata_o   <= head.wdata;
            add_o     <= head.write ? ADD_WRITE : ADD_READ;
            state     <= ISSUE;
          end
        end
        // add_o is a single-cycle request; the master latches it from ST_IDLE.
        ISSUE: begin
          add_o <= ADD_NOP;
`ifdef APB_SEQ_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (ready_i) begin
            rsp_valid_o <= 1'b1;
            rsp_write_o <= cur_write;
            rsp_rdata_o <= cur_write ? 32'h0 : rdata_i;
`ifdef APB_SEQ_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state       <= RESP;
          end
`ifdef APB_SEQ_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid_o <= 1'b1;
            rsp_write_o <= cur_write;
            rsp_rdata_o <= '0;
            rsp_err_q   <= 1'b1;
            state       <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed bench for apb_cmd_sequencer with a small behavioural APB master+slave (IDLE/SETUP/ACCESS, one register).
module tb_apb_cmd_sequencer;
  import apb_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic [1:0]  add;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [$clog2(DEPTH):0] level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pclk = ~pclk;

  apb_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_wdata_i (cmd_wdata),
    .add_o       (add),
    .wdata_o     (wdata),
    .ready_i     (ready),
    .rdata_i     (rdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_write_o (rsp_write),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .level_o     (level)
  );

  // Behavioural master + slave: add seen in IDLE -> SETUP -> ACCESS, pready in ACCESS when enabled.
  typedef enum logic [1:0] {M_IDLE, M_SETUP, M_ACCESS} m_state_t;
  m_state_t    m_state = M_IDLE;
  logic        m_write = 1'b0;
  logic        slave_en = 1'b1;
  logic [31:0] slave_reg = '0;
  logic [31:0] wlog [16];
  int          wcnt = 0;
  int          add_w_cyc = 0;
  int          add_r_cyc = 0;
  int          rsp_cyc = 0;

  assign ready = (m_state == M_ACCESS) && slave_en;
  assign rdata = slave_reg;

  always @(posedge pclk) begin
    if (add == ADD_WRITE) add_w_cyc <= add_w_cyc + 1;
    if (add == ADD_READ)  add_r_cyc <= add_r_cyc + 1;
    if (rsp_valid)        rsp_cyc   <= rsp_cyc + 1;
    if (preset) begin
      m_state   <= M_IDLE;
      slave_reg <= '0;
    end else begin
      case (m_state)
        M_IDLE: if (add != ADD_NOP) begin
          m_write <= (add == ADD_WRITE);
          m_state <= M_SETUP;
        end
        M_SETUP: m_state <= M_ACCESS;
        M_ACCESS: if (ready) begin
          if (m_write) begin
            slave_reg <= wdata;
            if (wcnt < 16) wlog[wcnt] <= wdata;
            wcnt <= wcnt + 1;
          end
          m_state <= M_IDLE;
        end
        default: m_state <= M_IDLE;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end at a negedge.
  task automatic push(input logic w, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_wdata = d;
    for (int i = 0; i < 100; i++) begin
      ok = cmd_ready;
      @(posedge pclk);
      @(negedge pclk);
      if (ok) break;
    end
    cmd_valid = 1'b0;
    check("push_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic get_rsp(input string tag, input logic w, input logic [31:0] d, input logic e);
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) break;
      @(negedge pclk);
    end
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_write"}, {31'd0, rsp_write}, {31'd0, w});
    check({tag, "_rdata"}, rsp_rdata, d);
    check({tag, "_err"},   {31'd0, rsp_err}, {31'd0, e});
    rsp_ready = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    rsp_ready = 1'b0;
  endtask

  // Counts posedges from the accepting edge until rsp_valid is seen.
  task automatic timed_cmd(input logic w, input logic [31:0] d, output int lat);
    check("timed_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_wdata = d;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge pclk);
      lat++;
      @(negedge pclk);
      cmd_valid = 1'b0;
      if (rsp_valid) break;
    end
  endtask

  task automatic wait_add(input logic [1:0] a);
    for (int i = 0; i < 20; i++) begin
      if (add == a) break;
      @(negedge pclk);
    end
    check("saw_issue", {30'd0, add}, {30'd0, a});
  endtask

  task automatic do_reset();
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    preset = 1'b0;
  endtask

  initial begin
    int lat;
    int w0, r0, wbase, p0, busy, changes;
    logic [31:0] snap;

    // Reset values
    do_reset();
    check("rst_add",       {30'd0, add}, 32'd0);
    check("rst_wdata",     wdata, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_write", {31'd0, rsp_write}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    check("rst_level",     32'(level), 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // WRITE then READ, latency from accept
    w0 = add_w_cyc;
    wbase = wcnt;
    timed_cmd(1'b1, 32'hDEADBEEF, lat);
    check("wr_latency", 32'(lat), 32'd5);
    get_rsp("wr", 1'b1, 32'h0, 1'b0);
    check("wr_add_cycles", 32'(add_w_cyc - w0), 32'd1);
    check("slave_reg_wr", slave_reg, 32'hDEADBEEF);
    r0 = add_r_cyc;
    timed_cmd(1'b0, 32'h1234_5678, lat);
    check("rd_latency", 32'(lat), 32'd5);
    get_rsp("rd", 1'b0, 32'hDEADBEEF, 1'b0);
    check("rd_add_cycles", 32'(add_r_cyc - r0), 32'd1);

    // Fill beyond DEPTH with responses blocked
    wbase = wcnt;
    for (int i = 1; i <= DEPTH + 1; i++) push(1'b1, 32'(i));
    check("fill_level", 32'(level), 32'(DEPTH));
    check("fill_ready", {31'd0, cmd_ready}, 32'd0);
    for (int i = 1; i <= DEPTH + 1; i++) get_rsp("fill", 1'b1, 32'h0, 1'b0);
    check("drain_level", 32'(level), 32'd0);
    check("fill_wcount", 32'(wcnt - wbase), 32'(DEPTH + 1));
    for (int i = 0; i <= DEPTH; i++) check("fill_order", wlog[wbase + i], 32'(i + 1));
    push(1'b0, 32'h0);
    get_rsp("fill_rd", 1'b0, 32'd5, 1'b0);

    // Backpressure in RESP with another command queued
    push(1'b0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) break;
      @(negedge pclk);
    end
    push(1'b1, 32'h77);
    snap = rsp_rdata;
    busy = 0;
    changes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== snap || rsp_write !== 1'b0) changes++;
      if (add !== ADD_NOP) busy++;
    end
    check("bp_snapshot", snap, 32'd5);
    check("bp_stable", 32'(changes), 32'd0);
    check("bp_no_issue", 32'(busy), 32'd0);
    check("bp_level", 32'(level), 32'd1);
    get_rsp("bp_rd", 1'b0, 32'd5, 1'b0);
    get_rsp("bp_wr", 1'b1, 32'h0, 1'b0);
    check("bp_slave_reg", slave_reg, 32'h77);

    // Reset during WAIT abandons the transfer
    p0 = rsp_cyc;
    push(1'b0, 32'h0);
    wait_add(ADD_READ);
    @(negedge pclk);
    preset = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    check("mid_level", 32'(level), 32'd0);
    check("mid_add", {30'd0, add}, 32'd0);
    check("mid_wdata", wdata, 32'd0);
    check("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      if (add !== ADD_NOP) busy++;
    end
    check("mid_no_issue", 32'(busy), 32'd0);
    check("mid_no_rsp", 32'(rsp_cyc - p0), 32'd0);
    timed_cmd(1'b0, 32'h0, lat);
    check("post_rst_latency", 32'(lat), 32'd5);
    get_rsp("post_rst_rd", 1'b0, 32'h0, 1'b0);

    // Slave never ready
    slave_en = 1'b0;
    push(1'b0, 32'h0);
    wait_add(ADD_READ);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge pclk);
      lat++;
      @(negedge pclk);
      if (rsp_valid) break;
    end
`ifdef APB_SEQ_TIMEOUT_EN
    check("tmo_edges", 32'(lat), 32'(TMO + 1));
    get_rsp("tmo", 1'b0, 32'h0, 1'b1);
`else
    check("no_tmo_rsp", {31'd0, rsp_valid}, 32'd0);
    check("no_tmo_edges", 32'(lat), 32'd60);
`endif
    slave_en = 1'b1;
    do_reset();
    check("final_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
